// File: rtl/chien_ctrl_p32.sv
// chien_ctrl_p32: Chien search sequencer that loads lambda, steps P lanes per beat, counts roots and flags failure.
// Build option CHIEN_EARLY_STOP_EN freezes the datapath once the expected root count is reached.
module chien_ctrl_p32 #(
   parameter int P          = 8,
   parameter int NUM_ITER   = 256,
   parameter int LAST_VALID = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lam_valid,
   output logic             lam_ready,
   input  logic [3:0]       lam_deg,
   output logic             cs_sel,
   output logic             cs_enable,
   input  logic [13*P-1:0]  sigma_bus,
   output logic             loc_valid,
   input  logic             loc_ready,
   output logic [P-1:0]     loc_mask,
   output logic             loc_last,
   output logic             done,
   output logic             fail,
   output logic [3:0]       root_cnt
);
   localparam int CW = $clog2(NUM_ITER + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] step_q, step_d;
   logic [3:0] deg_q, deg_d, root_cnt_q, root_cnt_d;
   logic loc_valid_q, loc_valid_d, fail_q, fail_d;
   logic [P-1:0] zero_lanes, last_keep;
   logic [7:0] pop;
   logic [8:0] sum;
   logic hs, adv, stopped, fail_calc;
`ifdef CHIEN_EARLY_STOP_EN
   assign stopped = state_q == RUN && root_cnt_q == deg_q;
`else
   assign stopped = 1'b0;
`endif
   always_comb begin
      zero_lanes = '0;
      last_keep = '0;
      for (int i = 0; i < P; i++) begin
         zero_lanes[i] = sigma_bus[13*i +: 13] == 13'd0;
         last_keep[i] = i < LAST_VALID;
      end
   end
   // step_q counts beats issued, so the beat on the bus is index step_q-1
   assign loc_last = loc_valid_q && step_q == CW'(NUM_ITER);
   assign loc_mask = (!loc_valid_q || stopped) ? '0 : loc_last ? zero_lanes & last_keep : zero_lanes;
   always_comb begin
      pop = '0;
      for (int i = 0; i < P; i++) pop = pop + 8'(loc_mask[i]);
   end
   assign sum = 9'(root_cnt_q) + 9'(pop);
   assign loc_valid = loc_valid_q;
   assign root_cnt = root_cnt_q;
   always_comb begin
      state_d = state_q;
      step_d = step_q;
      deg_d = deg_q;
      root_cnt_d = root_cnt_q;
      loc_valid_d = loc_valid_q;
      fail_d = fail_q;
      hs = loc_valid_q && loc_ready;
      adv = state_q == RUN && step_q < CW'(NUM_ITER) && (!loc_valid_q || loc_ready);
      lam_ready = state_q == IDLE;
      cs_sel = state_q == LOAD;
      cs_enable = cs_sel || (adv && !stopped);
      done = state_q == FINISH;
      fail_calc = deg_q > 4'd8 || root_cnt_q != deg_q;
      fail = done ? fail_calc : fail_q;
      if (hs) root_cnt_d = sum > 9'd15 ? 4'd15 : sum[3:0];
      unique case (state_q)
         IDLE: if (lam_valid) begin
            state_d = LOAD;
            deg_d = lam_deg;
            root_cnt_d = '0;
            step_d = '0;
            fail_d = 1'b0;
         end
         LOAD: begin
            state_d = RUN;
            step_d = CW'(1);
            loc_valid_d = 1'b1;
         end
         RUN: begin
            if (adv) step_d = step_q + CW'(1);
            loc_valid_d = adv ? 1'b1 : hs ? 1'b0 : loc_valid_q;
            if (hs && loc_last) state_d = FINISH;
         end
         FINISH: begin
            fail_d = fail_calc;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         step_q <= '0;
         deg_q <= '0;
         root_cnt_q <= '0;
         loc_valid_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q <= step_d;
         deg_q <= deg_d;
         root_cnt_q <= root_cnt_d;
         loc_valid_q <= loc_valid_d;
         fail_q <= fail_d;
      end
   end
endmodule

// File: tb/tb_chien_ctrl_p32.sv
// tb_chien_ctrl_p32: randomized directed bench for chien_ctrl_p32 with a root-map reference model and datapath emulation.
module tb_chien_ctrl_p32;
   localparam int P = 8;
   localparam int NUM_ITER = 256;
   localparam int LAST_VALID = 5;
   localparam logic [P-1:0] LV = P'((1 << LAST_VALID) - 1);
`ifdef CHIEN_EARLY_STOP_EN
   localparam bit ES = 1'b1;
`else
   localparam bit ES = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset;
   logic lam_valid, lam_ready, cs_sel, cs_enable, loc_valid, loc_ready, loc_last, done, fail;
   logic [3:0] lam_deg, root_cnt;
   logic [13*P-1:0] sigma_bus;
   logic [P-1:0] loc_mask;
   logic [P-1:0] zmap [NUM_ITER];
   int dp_step;
   int n_chk = 0;
   int n_fail = 0;

   chien_ctrl_p32 #(.P(P), .NUM_ITER(NUM_ITER), .LAST_VALID(LAST_VALID)) dut (
      .clk(clk), .reset(reset), .lam_valid(lam_valid), .lam_ready(lam_ready), .lam_deg(lam_deg),
      .cs_sel(cs_sel), .cs_enable(cs_enable), .sigma_bus(sigma_bus), .loc_valid(loc_valid),
      .loc_ready(loc_ready), .loc_mask(loc_mask), .loc_last(loc_last), .done(done), .fail(fail),
      .root_cnt(root_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13*P-1:0] gen(input int s);
      logic [13*P-1:0] v;
      for (int i = 0; i < P; i++)
         v[13*i +: 13] = (s < NUM_ITER && zmap[s][i]) ? 13'd0 : 13'($urandom_range(8191, 1));
      return v;
   endfunction

   function automatic int sat(input int r);
      return r > 15 ? 15 : r;
   endfunction

   function automatic int total_roots();
      int t = 0;
      for (int s = 0; s < NUM_ITER; s++)
         t += $countones(s == NUM_ITER - 1 ? zmap[s] & LV : zmap[s]);
      return t;
   endfunction

   task automatic clear_map();
      for (int s = 0; s < NUM_ITER; s++) zmap[s] = '0;
   endtask

   task automatic rand_roots(input int n);
      int s, l;
      for (int k = 0; k < n; k++) begin
         s = $urandom_range(NUM_ITER - 1, 0);
         l = $urandom_range(P - 1, 0);
         while (zmap[s][l] || (s == NUM_ITER - 1 && l >= LAST_VALID)) begin
            s = $urandom_range(NUM_ITER - 1, 0);
            l = $urandom_range(P - 1, 0);
         end
         zmap[s][l] = 1'b1;
      end
   endtask

   // Registered datapath: advances (or reloads on cs_sel) on edges where cs_enable was high
   task automatic tick();
      logic en, sel;
      en = cs_enable;
      sel = cs_sel;
      @(posedge clk);
      #1;
      if (en) begin
         dp_step = sel ? 0 : dp_step + 1;
         sigma_bus = gen(dp_step);
      end
   endtask

   task automatic run_cw(input logic [3:0] deg, input int bp_at, input int bp_len, input int rst_at, input bit noise);
      int beat, roots, n, stalls;
      bit seen, exp_fail, stop;
      logic [P-1:0] em;
      beat = 0; roots = 0; n = 0; stalls = 0; seen = 0; exp_fail = 0;
      lam_deg = deg;
      lam_valid = 1'b1;
      loc_ready = 1'b1;
      @(negedge clk);
      chk("lam_ready_idle", 32'(lam_ready), 1);
      tick();
      lam_valid = noise;
      lam_deg = 4'($urandom);
      @(negedge clk);
      chk("load_outputs", 32'({cs_sel, cs_enable, loc_valid, lam_ready}), 32'(4'b1100));
      tick();
      while (!seen && n < NUM_ITER + 64) begin
         loc_ready = !(beat == bp_at && stalls < bp_len);
         @(negedge clk);
         if (beat == rst_at) begin
            reset = 1'b0;
            #1;
            chk("reset_outputs", 32'({loc_valid, loc_last, cs_sel, cs_enable, done, fail, root_cnt, loc_mask}), 0);
            chk("reset_ready", 32'(lam_ready), 1);
            @(posedge clk);
            #1 reset = 1'b1;
            lam_valid = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("no_done_after_reset", 32'({done, lam_ready}), 1);
               @(posedge clk);
               #1;
            end
            return;
         end
         if (done) begin
            seen = 1;
            lam_valid = 1'b0;
            exp_fail = deg > 8 || sat(roots) != int'(deg);
            chk("done_cycle", 32'(n), 32'(NUM_ITER + stalls));
            chk("beat_total", 32'(beat), NUM_ITER);
            chk("root_cnt_final", 32'(root_cnt), 32'(sat(roots)));
            chk("fail_with_done", 32'(fail), 32'(exp_fail));
            chk("finish_outputs", 32'({loc_valid, lam_ready, cs_enable}), 0);
         end else begin
            stop = ES && sat(roots) == int'(deg);
            em = beat < NUM_ITER ? zmap[beat] : '0;
            if (beat == NUM_ITER - 1) em &= LV;
            if (stop) em = '0;
            chk("loc_valid", 32'(loc_valid), 1);
            chk("loc_mask", 32'(loc_mask), 32'(em));
            chk("loc_last", 32'(loc_last), 32'(beat == NUM_ITER - 1));
            chk("root_cnt_run", 32'(root_cnt), 32'(sat(roots)));
            chk("cs_run", 32'({cs_sel, cs_enable, lam_ready}),
                32'({1'b0, beat < NUM_ITER - 1 && loc_ready && !stop, 1'b0}));
            if (loc_ready) begin
               roots += $countones(em);
               beat++;
            end else stalls++;
         end
         tick();
         n++;
      end
      chk("done_seen", 32'(seen), 1);
      @(negedge clk);
      chk("idle_after", 32'({done, lam_ready, fail}), 32'({1'b0, 1'b1, exp_fail}));
      tick();
   endtask

   initial begin
      reset = 1'b0;
      lam_valid = 1'b0;
      lam_deg = '0;
      loc_ready = 1'b1;
      sigma_bus = '0;
      dp_step = 0;
      clear_map();
      #12;
      chk("reset_state", 32'({loc_valid, loc_last, cs_sel, cs_enable, done, fail, root_cnt}), 0);
      chk("reset_ready", 32'(lam_ready), 1);
      @(posedge clk);
      #1 reset = 1'b1;
      // two known roots, clean finish
      clear_map();
      zmap[5] = 8'h08;
      zmap[200] = 8'h01;
      run_cw(4'd2, -1, 0, -1, 1'b0);
      // degree above the number of roots, with ignored lam_valid traffic
      clear_map();
      rand_roots(2);
      run_cw(4'd3, -1, 0, -1, 1'b1);
      // backpressure at beat 10 and all lanes zero on the final beat
      clear_map();
      rand_roots(1);
      zmap[10][$urandom_range(P - 1, 0)] = 1'b1;
      zmap[NUM_ITER - 1] = '1;
      run_cw(4'(total_roots()), 10, 4, -1, 1'b0);
      // illegal degree forces failure even with matching root count
      clear_map();
      rand_roots(9);
      run_cw(4'd9, -1, 0, -1, 1'b0);
      // root counter saturation
      clear_map();
      rand_roots(20);
      run_cw(4'd8, $urandom_range(200, 1), 2, -1, 1'b0);
      // reset mid-codeword, then a normal codeword
      clear_map();
      rand_roots(3);
      run_cw(4'd3, -1, 0, 100, 1'b0);
      clear_map();
      rand_roots(4);
      run_cw(4'd4, -1, 0, -1, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
